ym3438_timer_regs: RTL and testbench

Timer register and counter stage for the OPN2 core. It sits directly downstream of the bus interface and consumes that block's write strobes, latched data bus and bank bit. It decodes registers 0x24–0x27 and runs Timer A (10-bit) and Timer B (8-bit with a ÷16 prescaler). It produces the `timer_a`/`timer_b` status flags that the interface block reads back and uses to drive IRQ.

---
 rtl/ym3438_timer_regs.sv | 129 ++++++++++++
 tb/tb_ym3438_timer_regs.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_timer_regs.sv
// OPN2 timer register file (0x24-0x27) with Timer A (10-bit) and Timer B (8-bit, /16 prescaled).
// Produces sticky overflow flags, a Timer A overflow pulse and the CH3 mode bits.
module ym3438_timer_regs (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       write_addr_en,
    input  logic       write_data_en,
    input  logic [7:0] data_bus,
    input  logic       bank,
    output logic       timer_a,
    output logic       timer_b,
    output logic       timer_a_ovf,
    output logic [1:0] ch3_mode
);

    logic [8:0] addr_reg;
    logic [9:0] ta_reg;
    logic [7:0] tb_reg;
    logic       load_a_reg, load_b_reg, en_a_reg, en_b_reg;
    logic       pend_a_reg, pend_a_next, pend_b_reg, pend_b_next;
    logic [9:0] cnt_a_reg, cnt_a_next;
    logic [7:0] cnt_b_reg, cnt_b_next;
    logic [3:0] psc_reg;
    logic       flag_a_reg, flag_a_next, flag_b_reg, flag_b_next;
    logic       ovf_a_reg;
    logic [1:0] ch3_reg;

    logic [3:0] wr_sel;
    logic       a_tick, b_tick, a_wrap, b_wrap;

    // One select line per register 0x024..0x027; bank=1 never matches.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign wr_sel[gi] = write_data_en && (addr_reg == (9'h024 + 9'(gi)));
        end
    endgenerate

    assign a_tick = sample_tick && load_a_reg;
    assign b_tick = sample_tick && load_b_reg && (psc_reg == 4'hF);
    assign a_wrap = a_tick && !pend_a_reg && (cnt_a_reg == 10'h3FF);
    assign b_wrap = b_tick && !pend_b_reg && (cnt_b_reg == 8'hFF);

    always_comb begin
        cnt_a_next  = cnt_a_reg;
        pend_a_next = pend_a_reg;
        flag_a_next = flag_a_reg;
        if (a_tick) begin
            cnt_a_next  = (pend_a_reg || a_wrap) ? ta_reg : cnt_a_reg + 10'd1;
            pend_a_next = 1'b0;
        end
        // Arming only happens while LOAD_A is 0, so it never collides with a consume.
        if (wr_sel[3] && data_bus[0] && !load_a_reg)
            pend_a_next = 1'b1;
        if (a_wrap && en_a_reg)
            flag_a_next = 1'b1;
        else if (wr_sel[3] && data_bus[4])
            flag_a_next = 1'b0;
    end

    always_comb begin
        cnt_b_next  = cnt_b_reg;
        pend_b_next = pend_b_reg;
        flag_b_next = flag_b_reg;
        if (b_tick) begin
            cnt_b_next  = (pend_b_reg || b_wrap) ? tb_reg : cnt_b_reg + 8'd1;
            pend_b_next = 1'b0;
        end
        if (wr_sel[3] && data_bus[1] && !load_b_reg)
            pend_b_next = 1'b1;
        if (b_wrap && en_b_reg)
            flag_b_next = 1'b1;
        else if (wr_sel[3] && data_bus[5])
            flag_b_next = 1'b0;
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            addr_reg   <= 9'h000;
            ta_reg     <= 10'h000;
            tb_reg     <= 8'h00;
            load_a_reg <= 1'b0;
            load_b_reg <= 1'b0;
            en_a_reg   <= 1'b0;
            en_b_reg   <= 1'b0;
            ch3_reg    <= 2'b00;
            pend_a_reg <= 1'b0;
            pend_b_reg <= 1'b0;
            cnt_a_reg  <= 10'h000;
            cnt_b_reg  <= 8'h00;
            psc_reg    <= 4'h0;
            flag_a_reg <= 1'b0;
            flag_b_reg <= 1'b0;
            ovf_a_reg  <= 1'b0;
        end else begin
            if (write_addr_en)
                addr_reg <= {bank, data_bus};
            if (wr_sel[0])
                ta_reg[9:2] <= data_bus;
            if (wr_sel[1])
                ta_reg[1:0] <= data_bus[1:0];
            if (wr_sel[2])
                tb_reg <= data_bus;
            if (wr_sel[3]) begin
                load_a_reg <= data_bus[0];
                load_b_reg <= data_bus[1];
                en_a_reg   <= data_bus[2];
                en_b_reg   <= data_bus[3];
                ch3_reg    <= data_bus[7:6];
            end
            if (sample_tick)
                psc_reg <= psc_reg + 4'd1;
            pend_a_reg <= pend_a_next;
            pend_b_reg <= pend_b_next;
            cnt_a_reg  <= cnt_a_next;
            cnt_b_reg  <= cnt_b_next;
            flag_a_reg <= flag_a_next;
            flag_b_reg <= flag_b_next;
            ovf_a_reg  <= a_wrap;
        end
    end

    assign timer_a     = flag_a_reg;
    assign timer_b     = flag_b_reg;
    assign timer_a_ovf = ovf_a_reg;
    assign ch3_mode    = ch3_reg;

endmodule

// File: tb/tb_ym3438_timer_regs.sv
// Directed vector bench for ym3438_timer_regs: register writes, tick runs and resets
// applied from a table, each followed by output and overflow-pulse-count checks.
module tb_ym3438_timer_regs;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       write_addr_en = 1'b0;
    logic       write_data_en = 1'b0;
    logic [7:0] data_bus = 8'h00;
    logic       bank = 1'b0;
    logic       timer_a, timer_b, timer_a_ovf;
    logic [1:0] ch3_mode;

    int total = 0;
    int bad = 0;
    int novf = 0;

    ym3438_timer_regs dut (
        .MCLK          (MCLK),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .write_addr_en (write_addr_en),
        .write_data_en (write_data_en),
        .data_bus      (data_bus),
        .bank          (bank),
        .timer_a       (timer_a),
        .timer_b       (timer_b),
        .timer_a_ovf   (timer_a_ovf),
        .ch3_mode      (ch3_mode)
    );

    always #5 MCLK = ~MCLK;

    typedef enum logic [1:0] {OP_WR, OP_TICK, OP_WRTICK, OP_RST} op_t;

    typedef struct {
        op_t        op;
        logic [8:0] addr;
        logic [7:0] data;
        int         n;
        logic       ea;
        logic       eb;
        logic       eovf;
        logic [1:0] ech3;
        int         enovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(op_t op, logic [8:0] addr, logic [7:0] data, int n,
                                logic ea, logic eb, logic eovf, logic [1:0] ech3, int enovf);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.n = n;
        v.ea = ea; v.eb = eb; v.eovf = eovf; v.ech3 = ech3; v.enovf = enovf;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MCLK);
        #1;
        if (timer_a_ovf) novf++;
    endtask

    task automatic check_outs(string tag, int idx, logic ea, logic eb, logic eovf, logic [1:0] ech3);
        chk({tag, "_timer_a"}, idx, int'(timer_a), int'(ea));
        chk({tag, "_timer_b"}, idx, int'(timer_b), int'(eb));
        chk({tag, "_ovf"}, idx, int'(timer_a_ovf), int'(eovf));
        chk({tag, "_ch3"}, idx, int'(ch3_mode), int'(ech3));
    endtask

    task automatic apply(vec_t v, int idx);
        novf = 0;
        case (v.op)
            OP_WR, OP_WRTICK: begin
                write_addr_en = 1'b1;
                bank = v.addr[8];
                data_bus = v.addr[7:0];
                cyc();
                write_addr_en = 1'b0;
                bank = 1'b0;
                data_bus = v.data;
                write_data_en = 1'b1;
                sample_tick = (v.op == OP_WRTICK);
                cyc();
                write_data_en = 1'b0;
                sample_tick = 1'b0;
                data_bus = 8'h00;
            end
            OP_TICK: begin
                sample_tick = 1'b1;
                repeat (v.n) cyc();
                sample_tick = 1'b0;
            end
            default: begin
                reset = 1'b1;
                #1;
            end
        endcase
        check_outs("vec", idx, v.ea, v.eb, v.eovf, v.ech3);
        chk("ovf_pulses", idx, novf, v.enovf);
        $display("vec %0d op=%0d addr=%03h data=%02h n=%0d -> a=%0b b=%0b ovf=%0b ch3=%0d pulses=%0d",
                 idx, v.op, v.addr, v.data, v.n, timer_a, timer_b, timer_a_ovf, ch3_mode, novf);
        if (v.op == OP_RST) begin
            @(posedge MCLK);
            #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        // Timer B from reset: load on tick16, overflow flag on tick32
        vecs.push_back(mk(OP_WR,   9'h026, 8'hFF, 0,  0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h0A, 0,  0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 15, 0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 15, 0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 1, 0, 2'd0, 0));
        // Timer A: TA=0x3FE, period 2
        vecs.push_back(mk(OP_WR,   9'h024, 8'hFF, 0,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_WR,   9'h025, 8'hFE, 0,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h0F, 0,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  1, 1, 1, 2'd0, 1));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  1, 1, 1, 2'd0, 1));
        // Flag clear, timer keeps running, then clear colliding with overflow
        vecs.push_back(mk(OP_WR,   9'h027, 8'h1F, 0,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  1, 1, 1, 2'd0, 1));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(OP_WRTICK, 9'h027, 8'h1F, 0, 1, 1, 1, 2'd0, 1));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h8F, 0,  1, 1, 0, 2'd2, 0));
        // Async reset mid-count, then nothing counts
        vecs.push_back(mk(OP_RST,  9'h000, 8'h00, 0,  0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 40, 0, 0, 0, 2'd0, 0));
        // Decode filtering: bank=1, 0x28 and 0x23 must be ignored
        vecs.push_back(mk(OP_WR,   9'h027, 8'h40, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h127, 8'h85, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h028, 8'hC5, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h023, 8'hC5, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1030, 0, 0, 0, 2'd1, 0));
        // Load control with EN_A=0: TA=0x3FC, period 4
        vecs.push_back(mk(OP_WR,   9'h024, 8'hFF, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h025, 8'h00, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h41, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 2,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h40, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 10, 0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h41, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 3,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 0, 1, 2'd1, 1));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 8,  0, 0, 1, 2'd1, 2));
        // LOAD 1->0->1 with no tick between re-arms the reload
        vecs.push_back(mk(OP_WR,   9'h027, 8'h40, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_WR,   9'h027, 8'h41, 0,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 4,  0, 0, 0, 2'd1, 0));
        vecs.push_back(mk(OP_TICK, 9'h000, 8'h00, 1,  0, 0, 1, 2'd1, 1));

        // Reset state
        repeat (3) @(posedge MCLK);
        #1;
        check_outs("reset", -1, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        $display("reset released: a=%0b b=%0b ovf=%0b ch3=%0d", timer_a, timer_b, timer_a_ovf, ch3_mode);

        foreach (vecs[i]) apply(vecs[i], i);

        // Address and data strobes together: data goes to the previously latched 0x027
        write_addr_en = 1'b1;
        data_bus = 8'h27;
        cyc();
        write_data_en = 1'b1;
        data_bus = 8'hC0;
        cyc();
        write_addr_en = 1'b0;
        write_data_en = 1'b0;
        chk("same_cycle_ch3", 100, int'(ch3_mode), 3);
        $display("same-cycle addr+data write -> ch3=%0d", ch3_mode);
        // Latch now holds 0x0C0, so a data-only write must be ignored
        write_data_en = 1'b1;
        data_bus = 8'h40;
        cyc();
        write_data_en = 1'b0;
        data_bus = 8'h00;
        cyc();
        chk("latched_c0_ignored", 101, int'(ch3_mode), 3);
        $display("data write to latched 0x0C0 -> ch3=%0d", ch3_mode);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
